// File: rtl/hazard_scoreboard_if.sv
// Operand/forwarding/issue/writeback bundle between the pipeline and the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int XLEN            = 32,
    parameter int NREGS           = 32,
    parameter int N_RD_PORTS      = 2,
    parameter int N_STAGES        = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SCW             = 16
);
    localparam int RW = $clog2(NREGS);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic                       flush_i;
    logic [N_RD_PORTS*RW-1:0]   rs_i;
    logic [N_RD_PORTS*XLEN-1:0] rs_data_i;
    logic [N_RD_PORTS*XLEN-1:0] rs_data_o;
    logic [N_STAGES-1:0]        fwd_valid_i;
    logic [N_STAGES-1:0]        fwd_rf_wr_en_i;
    logic [N_STAGES-1:0]        fwd_mem_read_i;
    logic [N_STAGES*RW-1:0]     fwd_rd_i;
    logic [N_STAGES*XLEN-1:0]   fwd_rd_data_i;
    logic                       issue_valid_i;
    logic                       issue_long_i;
    logic [RW-1:0]              issue_rd_i;
    logic                       wb_long_valid_i;
    logic [RW-1:0]              wb_long_rd_i;
    logic [XLEN-1:0]            wb_long_data_i;
    logic                       stall_o;
    logic                       load_use_stall_o;
    logic                       scb_stall_o;
    logic [NREGS-1:0]           busy_o;
    logic [OW-1:0]              outstanding_o;
    logic [SCW-1:0]             stall_count_o;

    modport master (
        output flush_i, rs_i, rs_data_i, fwd_valid_i, fwd_rf_wr_en_i, fwd_mem_read_i,
               fwd_rd_i, fwd_rd_data_i, issue_valid_i, issue_long_i, issue_rd_i,
               wb_long_valid_i, wb_long_rd_i, wb_long_data_i,
        input  rs_data_o, stall_o, load_use_stall_o, scb_stall_o, busy_o,
               outstanding_o, stall_count_o
    );

    modport slave (
        input  flush_i, rs_i, rs_data_i, fwd_valid_i, fwd_rf_wr_en_i, fwd_mem_read_i,
               fwd_rd_i, fwd_rd_data_i, issue_valid_i, issue_long_i, issue_rd_i,
               wb_long_valid_i, wb_long_rd_i, wb_long_data_i,
        output rs_data_o, stall_o, load_use_stall_o, scb_stall_o, busy_o,
               outstanding_o, stall_count_o
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW forwarding, per-register busy scoreboard for long ops, load-use / WAW /
// outstanding-limit stalls and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int XLEN            = 32,
    parameter int NREGS           = 32,
    parameter int N_RD_PORTS      = 2,
    parameter int N_STAGES        = 2,
    parameter int MEM_READ_STAGE  = 1,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SCW             = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    hazard_scoreboard_if.slave bus
);
    localparam int RW = $clog2(NREGS);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [NREGS-1:0]           busy_q;
    logic [NREGS-1:0]           busy_next;
    logic [OW-1:0]              outstanding_q;
    logic [SCW-1:0]             stall_count_q;
    logic [N_RD_PORTS*XLEN-1:0] rs_data;
    logic [RW-1:0]              rs_idx  [N_RD_PORTS];
    logic                       wb_hit  [N_RD_PORTS];
    logic                       lu_port [N_RD_PORTS];
    logic                       load_use;
    logic                       src_busy;
    logic                       waw;
    logic                       structural;
    logic                       scb_stall;
    logic                       stall;
    logic                       accept;

    // Operand resolution: stages are scanned oldest to youngest so the youngest
    // match overwrites, and the long writeback sits below every stage.
    always_comb begin
        rs_data  = bus.rs_data_i;
        load_use = 1'b0;
        src_busy = 1'b0;
        for (int p = 0; p < N_RD_PORTS; p++) begin
            rs_idx[p]  = bus.rs_i[p*RW +: RW];
            lu_port[p] = 1'b0;
            wb_hit[p]  = bus.wb_long_valid_i && (bus.wb_long_rd_i == rs_idx[p]) &&
                         (rs_idx[p] != '0);
            if (wb_hit[p])
                rs_data[p*XLEN +: XLEN] = bus.wb_long_data_i;
            for (int i = N_STAGES - 1; i >= 0; i--) begin
                if (bus.fwd_valid_i[i] && bus.fwd_rf_wr_en_i[i] &&
                    (bus.fwd_rd_i[i*RW +: RW] == rs_idx[p]) && (rs_idx[p] != '0)) begin
                    rs_data[p*XLEN +: XLEN] = bus.fwd_rd_data_i[i*XLEN +: XLEN];
                    lu_port[p] = (i < MEM_READ_STAGE) && bus.fwd_mem_read_i[i];
                end
            end
            load_use = load_use | lu_port[p];
            if (busy_q[rs_idx[p]] && !wb_hit[p])
                src_busy = 1'b1;
        end
    end

    assign waw        = bus.issue_valid_i && bus.issue_long_i && busy_q[bus.issue_rd_i];
    assign structural = bus.issue_valid_i && bus.issue_long_i &&
                        (outstanding_q == OW'(MAX_OUTSTANDING)) && !bus.wb_long_valid_i;
    assign scb_stall  = src_busy | waw | structural;
    assign stall      = load_use | scb_stall;
    assign accept     = bus.issue_valid_i && bus.issue_long_i && !stall;

    // Next busy vector: writeback clears first so a same-index issue set wins.
    always_comb begin
        busy_next = busy_q;
        if (bus.wb_long_valid_i)
            busy_next[bus.wb_long_rd_i] = 1'b0;
        if (accept && (bus.issue_rd_i != '0))
            busy_next[bus.issue_rd_i] = 1'b1;
    end

    // State update: reset clears all, flush clears tracking but not the perf counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q        <= '0;
            outstanding_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (stall && (stall_count_q != '1))
                stall_count_q <= stall_count_q + SCW'(1);
            if (bus.flush_i) begin
                busy_q        <= '0;
                outstanding_q <= '0;
            end else begin
                busy_q <= busy_next;
                if (accept && !bus.wb_long_valid_i)
                    outstanding_q <= outstanding_q + OW'(1);
                else if (!accept && bus.wb_long_valid_i && (outstanding_q != '0))
                    outstanding_q <= outstanding_q - OW'(1);
            end
        end
    end

    assign bus.rs_data_o        = rs_data;
    assign bus.stall_o          = stall;
    assign bus.load_use_stall_o = load_use;
    assign bus.scb_stall_o      = scb_stall;
    assign bus.busy_o           = busy_q;
    assign bus.outstanding_o    = outstanding_q;
    assign bus.stall_count_o    = stall_count_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: vector table, directed multi-cycle sequences,
// randomized traffic against a behavioural model, counter saturation.
module tb_hazard_scoreboard;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NP = 2;
    localparam int NS = 2;
    localparam int MRS = 1;
    localparam int MAXO = 4;
    localparam int SCW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .N_RD_PORTS(NP), .N_STAGES(NS),
                           .MAX_OUTSTANDING(MAXO), .SCW(SCW)) bus();

    hazard_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .N_RD_PORTS(NP), .N_STAGES(NS),
                        .MEM_READ_STAGE(MRS), .MAX_OUTSTANDING(MAXO), .SCW(SCW))
        dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    // stimulus variables
    logic [4:0]  rs_v [NP];
    logic [31:0] rsd_v [NP];
    logic        fv [NS], fwe [NS], fmr [NS];
    logic [4:0]  frd [NS];
    logic [31:0] fd [NS];
    logic        iv, il, wbv, flush;
    logic [4:0]  ird, wbrd;
    logic [31:0] wbd;

    // reference model state and expectations
    bit          busy_m [NREGS];
    int          out_m, sc_m;
    logic [31:0] e_data [NP];
    bit          e_lu_p [NP];
    bit          e_lu, e_scb, e_stall, e_acc;

    int total = 0;
    int pass  = 0;

    typedef struct {
        logic [4:0]  rs0, rs1;
        logic [31:0] rsd0, rsd1;
        logic [1:0]  fv, fwe, fmr;   // bit i = stage i
        logic [4:0]  rd0, rd1;
        logic [31:0] d0, d1;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic [31:0] e0, e1;
        logic        care0, care1, elu, est;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < NP; p++) begin rs_v[p] = '0; rsd_v[p] = '0; end
        for (int i = 0; i < NS; i++) begin
            fv[i] = 0; fwe[i] = 0; fmr[i] = 0; frd[i] = '0; fd[i] = '0;
        end
        iv = 0; il = 0; ird = '0; wbv = 0; wbrd = '0; wbd = '0; flush = 0;
    endtask

    task automatic settle();
        for (int p = 0; p < NP; p++) begin
            bus.rs_i[p*5 +: 5]       = rs_v[p];
            bus.rs_data_i[p*32 +: 32] = rsd_v[p];
        end
        for (int i = 0; i < NS; i++) begin
            bus.fwd_valid_i[i]          = fv[i];
            bus.fwd_rf_wr_en_i[i]       = fwe[i];
            bus.fwd_mem_read_i[i]       = fmr[i];
            bus.fwd_rd_i[i*5 +: 5]      = frd[i];
            bus.fwd_rd_data_i[i*32 +: 32] = fd[i];
        end
        bus.issue_valid_i   = iv;
        bus.issue_long_i    = il;
        bus.issue_rd_i      = ird;
        bus.wb_long_valid_i = wbv;
        bus.wb_long_rd_i    = wbrd;
        bus.wb_long_data_i  = wbd;
        bus.flush_i         = flush;
        #1;
    endtask

    // Expected combinational outputs from the current inputs and model state.
    task automatic model_eval();
        e_lu = 0; e_scb = 0;
        for (int p = 0; p < NP; p++) begin
            bit found;
            bit wbh;
            found = 0;
            e_data[p] = rsd_v[p];
            e_lu_p[p] = 0;
            wbh = wbv && (wbrd == rs_v[p]) && (rs_v[p] != 0);
            if (rs_v[p] != 0) begin
                for (int i = 0; i < NS; i++) begin
                    if (!found && fv[i] && fwe[i] && frd[i] == rs_v[p]) begin
                        found = 1;
                        e_data[p] = fd[i];
                        e_lu_p[p] = (i < MRS) && fmr[i];
                    end
                end
                if (!found && wbh) e_data[p] = wbd;
                if (busy_m[rs_v[p]] && !wbh) e_scb = 1;
            end
            if (e_lu_p[p]) e_lu = 1;
        end
        if (iv && il && busy_m[ird]) e_scb = 1;
        if (iv && il && out_m == MAXO && !wbv) e_scb = 1;
        e_stall = e_lu || e_scb;
        e_acc = iv && il && !e_stall;
    endtask

    task automatic model_commit();
        if (rst) begin
            for (int r = 0; r < NREGS; r++) busy_m[r] = 0;
            out_m = 0; sc_m = 0;
        end else begin
            if (e_stall && sc_m < 65535) sc_m++;
            if (flush) begin
                for (int r = 0; r < NREGS; r++) busy_m[r] = 0;
                out_m = 0;
            end else begin
                if (wbv) busy_m[wbrd] = 0;
                if (e_acc && ird != 0) busy_m[ird] = 1;
                if (e_acc && !wbv) out_m++;
                else if (!e_acc && wbv && out_m > 0) out_m--;
            end
        end
    endtask

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int r = 0; r < NREGS; r++) v[r] = busy_m[r];
        return v;
    endfunction

    task automatic tick();
        model_eval();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        model_eval();
        chk({tag, "_stall"}, bus.stall_o, e_stall);
        chk({tag, "_lu"}, bus.load_use_stall_o, e_lu);
        chk({tag, "_scb"}, bus.scb_stall_o, e_scb);
        chk({tag, "_busy"}, bus.busy_o, busy_vec());
        chk({tag, "_out"}, bus.outstanding_o, out_m);
        chk({tag, "_cnt"}, bus.stall_count_o, sc_m);
        for (int p = 0; p < NP; p++)
            if (!e_lu_p[p]) chk($sformatf("%s_data%0d", tag, p), bus.rs_data_o[p*32 +: 32], e_data[p]);
    endtask

    initial begin
        // rs0 rs1 rsd0 rsd1 fv fwe fmr rd0 rd1 d0 d1 wbv wbrd wbd e0 e1 care0 care1 elu est
        vecs[0] = '{5, 0, 32'h50, 32'h11, 2'b11, 2'b11, 2'b00, 5, 5, 32'hAAAA, 32'hBBBB,
                    0, 0, 0, 32'hAAAA, 32'h11, 1, 1, 0, 0};
        vecs[1] = '{3, 7, 32'h33, 32'h70, 2'b11, 2'b11, 2'b01, 7, 7, 32'hDEAD, 32'h5555,
                    0, 0, 0, 32'h33, 32'h0, 1, 0, 1, 1};
        vecs[2] = '{2, 7, 32'h22, 32'h70, 2'b10, 2'b10, 2'b10, 7, 7, 32'h0, 32'h1234,
                    0, 0, 0, 32'h22, 32'h1234, 1, 1, 0, 0};
        vecs[3] = '{0, 0, 32'h77, 32'h88, 2'b01, 2'b01, 2'b00, 0, 0, 32'hDEAD, 32'h0,
                    1, 0, 32'h99, 32'h77, 32'h88, 1, 1, 0, 0};
        vecs[4] = '{12, 6, 32'hC0, 32'h66, 2'b10, 2'b10, 2'b00, 0, 12, 32'h0, 32'h2222,
                    1, 12, 32'hCAFE0001, 32'h2222, 32'h66, 1, 1, 0, 0};
        vecs[5] = '{12, 12, 32'h1, 32'h2, 2'b00, 2'b00, 2'b00, 0, 0, 32'h0, 32'h0,
                    1, 12, 32'hF00D, 32'hF00D, 32'hF00D, 1, 1, 0, 0};
        vecs[6] = '{5, 5, 32'h1, 32'h2, 2'b11, 2'b10, 2'b00, 5, 5, 32'hAAAA, 32'hBBBB,
                    0, 0, 0, 32'hBBBB, 32'hBBBB, 1, 1, 0, 0};
        vecs[7] = '{8, 9, 32'h1, 32'h99, 2'b10, 2'b10, 2'b10, 0, 8, 32'h0, 32'h4444,
                    0, 0, 0, 32'h4444, 32'h99, 1, 1, 0, 0};

        // reset
        clear_inputs();
        rst = 1; settle(); tick(); tick();
        rst = 0; settle();
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_out", bus.outstanding_o, 0);
        chk("rst_cnt", bus.stall_count_o, 0);
        chk("rst_stall", bus.stall_o, 0);

        // forwarding vector table
        for (int k = 0; k < 8; k++) begin
            clear_inputs();
            rs_v[0] = vecs[k].rs0; rs_v[1] = vecs[k].rs1;
            rsd_v[0] = vecs[k].rsd0; rsd_v[1] = vecs[k].rsd1;
            for (int i = 0; i < NS; i++) begin
                fv[i] = vecs[k].fv[i]; fwe[i] = vecs[k].fwe[i]; fmr[i] = vecs[k].fmr[i];
            end
            frd[0] = vecs[k].rd0; frd[1] = vecs[k].rd1;
            fd[0] = vecs[k].d0; fd[1] = vecs[k].d1;
            wbv = vecs[k].wbv; wbrd = vecs[k].wbrd; wbd = vecs[k].wbd;
            settle();
            if (vecs[k].care0) chk($sformatf("vec%0d_d0", k), bus.rs_data_o[31:0], vecs[k].e0);
            if (vecs[k].care1) chk($sformatf("vec%0d_d1", k), bus.rs_data_o[63:32], vecs[k].e1);
            chk($sformatf("vec%0d_lu", k), bus.load_use_stall_o, vecs[k].elu);
            chk($sformatf("vec%0d_stall", k), bus.stall_o, vecs[k].est);
            tick();
        end

        // long op rd=9, dependent stalls until writeback three cycles later
        clear_inputs(); iv = 1; il = 1; ird = 9; settle();
        chk("a_issue_stall", bus.stall_o, 0);
        tick();
        clear_inputs(); rs_v[0] = 9; rsd_v[0] = 32'h9; settle();
        chk("a_scb", bus.scb_stall_o, 1);
        chk("a_busy9", bus.busy_o[9], 1);
        check_all("a1");
        tick(); tick();
        wbv = 1; wbrd = 9; wbd = 32'hCAFE; settle();
        chk("a_wb_stall", bus.stall_o, 0);
        chk("a_wb_data", bus.rs_data_o[31:0], 32'hCAFE);
        tick();
        clear_inputs(); settle();
        chk("a_busy9_clr", bus.busy_o[9], 0);
        chk("a_out0", bus.outstanding_o, 0);

        // outstanding limit
        for (int r = 1; r <= 4; r++) begin
            clear_inputs(); iv = 1; il = 1; ird = 5'(r); settle();
            chk($sformatf("b_acc%0d", r), bus.stall_o, 0);
            tick();
        end
        clear_inputs(); iv = 1; il = 1; ird = 5; settle();
        chk("b_struct", bus.scb_stall_o, 1);
        chk("b_out_max", bus.outstanding_o, 4);
        wbv = 1; wbrd = 1; settle();
        chk("b_struct_wb", bus.stall_o, 0);
        tick();
        clear_inputs(); settle();
        chk("b_out_hold", bus.outstanding_o, 4);
        chk("b_busy5", bus.busy_o[5], 1);
        chk("b_busy1", bus.busy_o[1], 0);

        // WAW on busy rd=3 (writeback elsewhere keeps the limit out of it)
        clear_inputs(); iv = 1; il = 1; ird = 3; wbv = 1; wbrd = 2; settle();
        chk("c_waw", bus.scb_stall_o, 1);
        check_all("c");

        // flush clears tracking, counter kept
        clear_inputs(); flush = 1; settle(); tick();
        flush = 0; settle();
        chk("d_busy", bus.busy_o, 0);
        chk("d_out", bus.outstanding_o, 0);
        chk("d_cnt_kept", bus.stall_count_o != 0, 1);
        check_all("d");

        // issue to x0 never sets busy
        iv = 1; il = 1; ird = 0; settle();
        chk("e_x0_stall", bus.stall_o, 0);
        tick();
        clear_inputs(); settle();
        chk("e_x0_busy", bus.busy_o, 0);
        chk("e_x0_out", bus.outstanding_o, 1);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 39) == 0);
            for (int p = 0; p < NP; p++) begin
                rs_v[p] = 5'($urandom_range(0, 7)); rsd_v[p] = $urandom;
            end
            for (int i = 0; i < NS; i++) begin
                fv[i] = ($urandom_range(0, 3) != 0); fwe[i] = ($urandom_range(0, 3) != 0);
                fmr[i] = ($urandom_range(0, 3) == 0); frd[i] = 5'($urandom_range(0, 7));
                fd[i] = $urandom;
            end
            iv = ($urandom_range(0, 1) == 1); il = ($urandom_range(0, 2) != 0);
            ird = 5'($urandom_range(0, 7));
            wbv = ($urandom_range(0, 2) == 0); wbrd = 5'($urandom_range(0, 7)); wbd = $urandom;
            settle();
            check_all($sformatf("rnd%0d", n));
            tick();
        end
        rst = 0;

        // stall counter saturation and reset
        clear_inputs(); rst = 1; settle(); tick();
        rst = 0;
        fv[0] = 1; fwe[0] = 1; fmr[0] = 1; frd[0] = 7; rs_v[1] = 7; settle();
        chk("s_lu", bus.load_use_stall_o, 1);
        repeat (65534) tick();
        chk("s_cnt_fffe", bus.stall_count_o, 16'hFFFE);
        tick();
        chk("s_cnt_ffff", bus.stall_count_o, 16'hFFFF);
        repeat (4) tick();
        chk("s_cnt_sat", bus.stall_count_o, 16'hFFFF);
        clear_inputs(); flush = 1; settle(); tick();
        flush = 0; settle();
        chk("s_flush_keep", bus.stall_count_o, 16'hFFFF);
        rst = 1; settle(); tick();
        rst = 0; settle();
        chk("s_rst_cnt", bus.stall_count_o, 0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational forwarding unit.
- Resolves RAW hazards for N_RD_PORTS source operands in decode/execute: forwards from N_STAGES pipeline stages and from a variable-latency (long-op) writeback port.
- Keeps a per-register busy scoreboard so multi-cycle ops (divider, wait-stated loads) stall dependents until writeback.
- Also generates load-use, WAW and structural (outstanding-limit) stalls, and counts stall cycles for performance monitoring.

Parameters:
XLEN, 32, data width
NREGS, 32, architectural registers; RW = $clog2(NREGS) is a derived localparam
N_RD_PORTS, 2, source operands checked per cycle
N_STAGES, 2, forwarding sources; index 0 = youngest
MEM_READ_STAGE, 1, stages with index < this cannot forward load data
MAX_OUTSTANDING, 4, maximum long ops in flight
SCW, 16, stall counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  pipeline flush; the long-op unit is killed by the same signal
rs_i  in  N_RD_PORTS*RW  source register indices
rs_data_i  in  N_RD_PORTS*XLEN  register file read data
rs_data_o  out  N_RD_PORTS*XLEN  resolved operand data
fwd_valid_i  in  N_STAGES  stage holds a valid instruction
fwd_rf_wr_en_i  in  N_STAGES  stage writes rd
fwd_mem_read_i  in  N_STAGES  stage is a load
fwd_rd_i  in  N_STAGES*RW  stage destination
fwd_rd_data_i  in  N_STAGES*XLEN  stage result
issue_valid_i  in  1  decode instruction attempting to issue
issue_long_i  in  1  issuing instruction is a long op
issue_rd_i  in  RW  issuing destination
wb_long_valid_i  in  1  long-op writeback this cycle
wb_long_rd_i  in  RW  long-op writeback destination
wb_long_data_i  in  XLEN  long-op result
stall_o  out  1  OR of all stall causes (combinational)
load_use_stall_o  out  1  load-use cause (combinational)
scb_stall_o  out  1  scoreboard, WAW or structural cause (combinational)
busy_o  out  NREGS  registered scoreboard bits
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  registered long ops in flight
stall_count_o  out  SCW  registered stall-cycle counter

Behaviour:
- Register x0:
  - rs==0 never forwards and never stalls; rs_data_o = rs_data_i.
  - Issue to rd==0 never sets busy.
- Forwarding, per port p. Stage i matches when fwd_valid_i[i] && fwd_rf_wr_en_i[i] && fwd_rd_i[i]==rs[p] && rs[p]!=0.
- Data priority, highest first:
  - lowest matching stage index;
  - then the long writeback (wb_long_valid_i && wb_long_rd_i==rs[p]);
  - then rs_data_i.
- Load-use: if the highest-priority matching stage has i < MEM_READ_STAGE and fwd_mem_read_i[i], then load_use_stall_o=1. Data from that port is don't-care. Older stages must not override a younger load match.
- Scoreboard stall (scb_stall_o=1) when any of:
  - busy[rs[p]] for any port, unless the same cycle's long writeback targets rs[p] (that data is forwarded instead);
  - issue_valid_i && issue_long_i && busy[issue_rd_i] (WAW);
  - issue_valid_i && issue_long_i && outstanding_o==MAX_OUTSTANDING, unless wb_long_valid_i is high the same cycle.
- Accept = issue_valid_i && issue_long_i && !stall_o.
- Sequential updates, priority order:
  - rst_i: busy, outstanding and stall_count all go to 0.
  - flush_i (no reset): busy and outstanding go to 0; stall_count keeps counting.
  - Otherwise:
    - busy[wb_long_rd_i] clears on writeback.
    - busy[issue_rd_i] sets on accept with rd!=0. Set wins over clear on the same index.
    - outstanding +1 on accept, -1 on writeback (no decrement at 0), unchanged when both occur.
- stall_count_o increments each cycle stall_o=1 and saturates at all-ones. Only rst_i clears it.
- A writeback to a non-busy rd only decrements outstanding.
- Latency: all stall and forward outputs are combinational from inputs and current state. Busy and outstanding changes take effect on the next cycle.

Test Plan:
- Stage0 (rd=5, data 0xAAAA, no load) and stage1 (rd=5, data 0xBBBB) both valid, rs_i port0=5 -> rs_data_o port0=0xAAAA, stall_o=0.
- Stage0 load rd=7, MEM_READ_STAGE=1, rs port1=7 -> load_use_stall_o=1; same load in stage1 with data 0x1234 -> forwards 0x1234, no stall.
- Accept long op rd=9; next cycle rs=9 -> scb_stall_o=1, busy_o[9]=1. Three cycles later wb_long rd=9, data 0xCAFE -> same cycle stall_o=0, rs_data_o=0xCAFE; next cycle busy_o[9]=0.
- Issue 4 long ops to rd 1..4, then a 5th -> structural stall, outstanding_o=4. Writeback in the same cycle -> 5th accepted, outstanding_o stays 4.
- Long op to rd=3 while busy[3] -> WAW stall. rs=0 with stage0 rd=0 wr_en -> no forward, no stall. Issue to rd=0 -> busy_o unchanged.
- busy bits set, flush_i pulse -> busy_o=0 and outstanding_o=0 next cycle. stall_count_o retained; rst_i clears it. Force stall for 2^SCW+3 cycles -> counter saturates at 0xFFFF.
